// File: rtl/imem_arbiter_if.sv
// Bundle of per-CPU fetch handshakes plus the shared instruction-memory read port.
// The arbiter is the slave side; requesters and memory together form the master side.
interface imem_arbiter_if #(
  parameter int nCPUs  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [nCPUs-1:0]             reqValid;
  logic [nCPUs-1:0][ADDR_W-1:0] reqAddr;
  logic [nCPUs-1:0]             reqReady;
  logic [nCPUs-1:0]             rspValid;
  logic [nCPUs-1:0][DATA_W-1:0] rspData;
  logic                         memRead;
  logic [ADDR_W-1:0]            memAddr;
  logic [DATA_W-1:0]            memData;

  modport slave (
    input  reqValid, reqAddr, memData,
    output reqReady, rspValid, rspData, memRead, memAddr
  );
  modport master (
    output reqValid, reqAddr, memData,
    input  reqReady, rspValid, rspData, memRead, memAddr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction memory among nCPUs fetchers.
// Fully pipelined: one grant per cycle, responses returned in grant order LAT+1 cycles later.
module imem_arbiter #(
  parameter int nCPUs  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);
  localparam int ID_W = (nCPUs > 1) ? $clog2(nCPUs) : 1;
  typedef logic [ID_W-1:0] id_t;

  id_t                          ptr_d, ptr_q;
  id_t                          grant_id;
  logic                         grant_any;
  logic [nCPUs-1:0]             grant;
  logic [LAT-1:0]               vld_pipe_d, vld_pipe_q;
  logic [LAT-1:0][ID_W-1:0]     id_pipe_d, id_pipe_q;
  logic [nCPUs-1:0]             rsp_valid_d, rsp_valid_q;
  logic [nCPUs-1:0][DATA_W-1:0] rsp_data_d, rsp_data_q;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    id_t idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    ptr_d     = ptr_q;
    for (int k = nCPUs - 1; k >= 0; k--) begin
      idx = id_t'((int'(ptr_q) + k) % nCPUs);
      if (bus.reqValid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    if (rst) grant_any = 1'b0;
    if (grant_any) begin
      grant[grant_id] = 1'b1;
      ptr_d = (int'(grant_id) == nCPUs - 1) ? '0 : id_t'(grant_id + 1'b1);
    end
  end

  assign bus.reqReady = grant;
  assign bus.memRead  = grant_any;
  assign bus.memAddr  = grant_any ? bus.reqAddr[grant_id] : '0;

  // Stage s holds the grant issued s+1 cycles ago; the last stage lines up with memData.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[0] = grant_any;
    id_pipe_d[0]  = grant_id;
    for (int s = 1; s < LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      id_pipe_d[s]  = id_pipe_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < nCPUs; i++) begin
      if (vld_pipe_q[LAT-1] && (id_pipe_q[LAT-1] == id_t'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = bus.memData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs read as zero for the whole reset window, including its first cycle.
  assign bus.rspValid = rsp_valid_q & {nCPUs{~rst}};
  assign bus.rspData  = rst ? '0 : rsp_data_q;
endmodule
